// File: rtl/ace_instbuf.sv
// ace_instbuf: 8-wide fetch to 4-wide decode instruction queue.
// Ports: clock/reset_n, fetch group in, decode group out, full/empty, flush.
module ace_instbuf #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         retire_flush_i,
  input  logic [255:0] fetch_inst_i,
  input  logic [7:0]   fetch_vld_i,
  input  logic         pipe_load_decode_i,
  output logic [127:0] inst_o,
  output logic [3:0]   inst_vld_o,
  output logic         instbuf_full_o,
  output logic         instbuf_empty_o
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [31:0] mem [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;

  cnt_t npush;
  cnt_t npop;
  cnt_t push_n;
  cnt_t pop_n;
  ptr_t wr_idx [8];
  logic push_ok;
  logic pop_ok;

  // Each valid lane lands at tail plus the
  // number of valid lanes below it.
  always_comb begin
    npush = '0;
    for (int k = 0; k < 8; k++) begin
      wr_idx[k] = tail + npush[PTR_W-1:0];
      npush     = npush + cnt_t'(fetch_vld_i[k]);
    end
  end

  assign instbuf_full_o  = count > cnt_t'(DEPTH - 8);
  assign instbuf_empty_o = count == '0;

  assign push_ok = (|fetch_vld_i) && !instbuf_full_o
                   && !retire_flush_i;
  assign pop_ok  = pipe_load_decode_i && !retire_flush_i;

  assign npop   = (count > cnt_t'(4)) ? cnt_t'(4) : count;
  assign push_n = push_ok ? npush : '0;
  assign pop_n  = pop_ok ? npop : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (retire_flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n[PTR_W-1:0];
      tail  <= tail + push_n[PTR_W-1:0];
      count <= count + push_n - pop_n;
    end
  end

  // Storage is not reset; stale entries are
  // masked by the count-derived valids.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (fetch_vld_i[k]) begin
          mem[wr_idx[k]] <= fetch_inst_i[32*k +: 32];
        end
      end
    end
  end

  always_comb begin
    inst_o     = '0;
    inst_vld_o = '0;
    for (int j = 0; j < 4; j++) begin
      if (count > cnt_t'(j)) begin
        inst_vld_o[j]     = 1'b1;
        inst_o[32*j +: 32] = mem[head + ptr_t'(j)];
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    push_ok |-> (count + npush <= cnt_t'(DEPTH)));

  a_count_bound: assert property (
    @(posedge clock) disable iff (!reset_n)
    count <= cnt_t'(DEPTH));

endmodule

// File: tb/tb_ace_instbuf.sv
// tb_ace_instbuf: scoreboard bench for ace_instbuf.
// Queue model tracks buffered instructions in program order.
module tb_ace_instbuf;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         retire_flush_i;
  logic [255:0] fetch_inst_i;
  logic [7:0]   fetch_vld_i;
  logic         pipe_load_decode_i;
  logic [127:0] inst_o;
  logic [3:0]   inst_vld_o;
  logic         instbuf_full_o;
  logic         instbuf_empty_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sb [$];

  ace_instbuf dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .retire_flush_i     (retire_flush_i),
    .fetch_inst_i       (fetch_inst_i),
    .fetch_vld_i        (fetch_vld_i),
    .pipe_load_decode_i (pipe_load_decode_i),
    .inst_o             (inst_o),
    .inst_vld_o         (inst_vld_o),
    .instbuf_full_o     (instbuf_full_o),
    .instbuf_empty_o    (instbuf_empty_o)
  );

  always #5 clock = ~clock;

  function automatic logic [255:0] lanes(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [127:0] exp_inst();
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (j < sb.size()) r[32*j +: 32] = sb[j];
    return r;
  endfunction

  function automatic logic [3:0] exp_vld();
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = (j < sb.size());
    return r;
  endfunction

  function automatic logic exp_full();
    return sb.size() > 8;
  endfunction

  function automatic logic exp_empty();
    return sb.size() == 0;
  endfunction

  // One clock of stimulus; the scoreboard is updated
  // from the pre-edge occupancy, like the hardware.
  task automatic drive(input logic [7:0] v,
                       input logic [255:0] d,
                       input logic ld,
                       input logic fl);
    int c;
    c = sb.size();
    fetch_vld_i        = v;
    fetch_inst_i       = d;
    pipe_load_decode_i = ld;
    retire_flush_i     = fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (ld)
        for (int j = 0; j < 4; j++)
          if (sb.size() > 0) void'(sb.pop_front());
      if (v != 8'h00 && c <= 8)
        for (int k = 0; k < 8; k++)
          if (v[k]) sb.push_back(d[32*k +: 32]);
    end
    @(posedge clock);
    #1;
    fetch_vld_i        = '0;
    fetch_inst_i       = '0;
    pipe_load_decode_i = 1'b0;
    retire_flush_i     = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (instbuf_empty_o !== 1'b1 || instbuf_full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got e=%b f=%b want e=1 f=0",
               instbuf_empty_o, instbuf_full_o);
    end
    n_chk++;
    if (inst_vld_o !== 4'b0000 || inst_o !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%h want v=0 d=0",
               inst_vld_o, inst_o);
    end
    drive(8'hFF, lanes(32'h900), 1'b0, 1'b0);
    drive(8'hFF, lanes(32'h910), 1'b0, 1'b0);
    n_chk++;
    if (instbuf_full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: got f=%b want f=1", instbuf_full_o);
    end
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    n_chk++;
    if (instbuf_empty_o !== 1'b1 || instbuf_full_o !== 1'b0
        || inst_vld_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: got e=%b f=%b v=%b want e=1 f=0 v=0",
               instbuf_empty_o, instbuf_full_o, inst_vld_o);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    logic [127:0] want;
    drive(8'hFF, lanes(32'h100), 1'b0, 1'b0);
    want = {32'h103, 32'h102, 32'h101, 32'h100};
    n_chk++;
    if (inst_o !== want || inst_vld_o !== 4'hF) begin
      n_fail++;
      $display("FAIL basic_g0: got %h/%b want %h/f",
               inst_o, inst_vld_o, want);
    end
    drive(8'h00, '0, 1'b1, 1'b0);
    want = {32'h107, 32'h106, 32'h105, 32'h104};
    n_chk++;
    if (inst_o !== want || inst_o !== exp_inst()) begin
      n_fail++;
      $display("FAIL basic_g1: got %h want %h", inst_o, want);
    end
    drive(8'h00, '0, 1'b1, 1'b0);
    n_chk++;
    if (instbuf_empty_o !== 1'b1 || inst_vld_o !== 4'h0) begin
      n_fail++;
      $display("FAIL basic_empty: got e=%b v=%b want e=1 v=0",
               instbuf_empty_o, inst_vld_o);
    end
  endtask

  task automatic test_compaction();
    logic [127:0] want;
    drive(8'b1010_0101, lanes(32'h200), 1'b0, 1'b0);
    want = {32'h207, 32'h205, 32'h202, 32'h200};
    n_chk++;
    if (inst_o !== want || inst_vld_o !== 4'hF) begin
      n_fail++;
      $display("FAIL compact: got %h/%b want %h/f",
               inst_o, inst_vld_o, want);
    end
    drive(8'h00, '0, 1'b1, 1'b0);
    n_chk++;
    if (instbuf_empty_o !== exp_empty()) begin
      n_fail++;
      $display("FAIL compact_drain: got e=%b want %b",
               instbuf_empty_o, exp_empty());
    end
  endtask

  task automatic test_full_drop();
    drive(8'hFF, lanes(32'h400), 1'b0, 1'b0);
    n_chk++;
    if (instbuf_full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at8: got f=%b want 0", instbuf_full_o);
    end
    drive(8'hFF, lanes(32'h408), 1'b0, 1'b0);
    n_chk++;
    if (instbuf_full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_at16: got f=%b want 1", instbuf_full_o);
    end
    drive(8'hFF, lanes(32'h300), 1'b0, 1'b0);
    n_chk++;
    if (sb.size() != 16) begin
      n_fail++;
      $display("FAIL full_model: got %0d want 16", sb.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (inst_o !== exp_inst() || inst_vld_o !== exp_vld()
          || instbuf_full_o !== exp_full()) begin
        n_fail++;
        $display("FAIL full_pop%0d: got %h/%b/f%b want %h/%b/f%b",
                 i, inst_o, inst_vld_o, instbuf_full_o,
                 exp_inst(), exp_vld(), exp_full());
      end
      drive(8'h00, '0, 1'b1, 1'b0);
    end
    n_chk++;
    if (instbuf_empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drained: got e=%b want 1", instbuf_empty_o);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      drive(8'hFF, lanes(32'h1000 + 32'(i) * 32'h10), 1'b1, 1'b0);
      n_chk++;
      if (inst_o !== exp_inst() || inst_vld_o !== exp_vld()
          || instbuf_full_o !== exp_full()
          || instbuf_empty_o !== exp_empty()) begin
        n_fail++;
        $display("FAIL wrap%0d: got %h/%b/f%b want %h/%b/f%b",
                 i, inst_o, inst_vld_o, instbuf_full_o,
                 exp_inst(), exp_vld(), exp_full());
      end
    end
    while (sb.size() > 0) begin
      drive(8'h00, '0, 1'b1, 1'b0);
      n_chk++;
      if (inst_o !== exp_inst() || inst_vld_o !== exp_vld()) begin
        n_fail++;
        $display("FAIL wrap_drain: got %h/%b want %h/%b",
                 inst_o, inst_vld_o, exp_inst(), exp_vld());
      end
    end
  endtask

  task automatic test_flush();
    drive(8'h0F, lanes(32'h500), 1'b0, 1'b0);
    drive(8'hFF, lanes(32'h600), 1'b1, 1'b1);
    n_chk++;
    if (instbuf_empty_o !== 1'b1 || inst_vld_o !== 4'h0
        || inst_o !== '0) begin
      n_fail++;
      $display("FAIL flush: got e=%b v=%b d=%h want e=1 v=0 d=0",
               instbuf_empty_o, inst_vld_o, inst_o);
    end
    drive(8'b0000_0011, lanes(32'h700), 1'b0, 1'b0);
    n_chk++;
    if (inst_vld_o !== 4'b0011
        || inst_o !== {64'h0, 32'h701, 32'h700}) begin
      n_fail++;
      $display("FAIL flush_after: got %b/%h want 0011/700,701",
               inst_vld_o, inst_o);
    end
    drive(8'h00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic       ld;
    logic       fl;
    for (int i = 0; i < 300; i++) begin
      v  = 8'($urandom);
      ld = 1'($urandom);
      fl = ($urandom_range(0, 19) == 0);
      drive(v, lanes(32'h8000 + 32'(i) * 32'h10), ld, fl);
      n_chk++;
      if (inst_o !== exp_inst() || inst_vld_o !== exp_vld()
          || instbuf_full_o !== exp_full()
          || instbuf_empty_o !== exp_empty()) begin
        n_fail++;
        $display("FAIL rand%0d: got %h/%b/f%b/e%b want %h/%b/f%b/e%b",
                 i, inst_o, inst_vld_o, instbuf_full_o,
                 instbuf_empty_o, exp_inst(), exp_vld(),
                 exp_full(), exp_empty());
      end
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    retire_flush_i     = 1'b0;
    fetch_inst_i       = '0;
    fetch_vld_i        = '0;
    pipe_load_decode_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    test_reset();
    test_basic();
    test_compaction();
    test_full_drop();
    test_wrap();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
